// File: rtl/a2d_arb_pkg.sv
// Shared types and widths for the A2D converter arbiter.
package a2d_arb_pkg;

  localparam int unsigned CHNL_W = 3;
  localparam int unsigned RES_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first asserted req at or after (last+1) mod NUM_REQ wins.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  logic [IDX_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [IDX_W:0]       off;
  logic [IDX_W:0]       sum;
  logic                 found;

  // Rotate the doubled request vector so the search always begins at bit 0.
  always_comb begin
    start = (last >= IDX_W'(NUM_REQ - 1)) ? '0 : last + IDX_W'(1);
    dbl   = {req, req} >> start;
    found = 1'b0;
    off   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(j);
      end
    end
    sum = {1'b0, start} + off;
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    win_idx = sum[IDX_W-1:0];
    win     = found ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin sharing of one A2D_intf converter among NUM_REQ requesters,
// with a watchdog that releases the converter when a conversion never completes.
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TMO_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [CHNL_W*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [RES_W-1:0]          rd_res,
  output logic                      tmo_err,
  input  logic                      clr_err,
  output logic                      busy,
  output logic [CHNL_W-1:0]         a2d_chnnl,
  output logic                      a2d_strt,
  input  logic                      a2d_cmplt,
  input  logic [RES_W-1:0]          a2d_res
);

  localparam int unsigned      IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
  // Counter starts at 0 in the first WAIT cycle, so this value marks the last allowed one.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t state, state_nxt;

  logic [IDX_W-1:0]   sel, sel_nxt, last, last_nxt;
  logic [TMO_W-1:0]   wdog, wdog_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt, pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic [RES_W-1:0]   rd_res_nxt;
  logic [CHNL_W-1:0]  a2d_chnnl_nxt;
  logic               tmo_err_nxt, busy_nxt, a2d_strt_nxt;
  logic               wdog_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (last),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  assign wdog_end = (wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (a2d_cmplt || wdog_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; completion beats the watchdog.
  always_comb begin
    gnt_nxt       = gnt;
    done_nxt      = '0;
    rd_res_nxt    = rd_res;
    tmo_err_nxt   = tmo_err & ~clr_err;
    busy_nxt      = (state_nxt != IDLE);
    a2d_chnnl_nxt = a2d_chnnl;
    a2d_strt_nxt  = 1'b0;
    sel_nxt       = sel;
    last_nxt      = last;
    wdog_nxt      = wdog;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt      = pick_idx;
          gnt_nxt      = pick_win;
          a2d_strt_nxt = 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) a2d_chnnl_nxt = req_chnnl[i*CHNL_W +: CHNL_W];
          end
        end
      end
      START: wdog_nxt = '0;
      WAIT: begin
        wdog_nxt = wdog + TMO_W'(1);
        if (a2d_cmplt) begin
          rd_res_nxt = a2d_res;
          done_nxt   = gnt;
          gnt_nxt    = '0;
          last_nxt   = sel;
        end else if (wdog_end) begin
          tmo_err_nxt = 1'b1;
          rd_res_nxt  = '0;
          done_nxt    = gnt;
          gnt_nxt     = '0;
          last_nxt    = sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      rd_res    <= '0;
      tmo_err   <= 1'b0;
      busy      <= 1'b0;
      a2d_chnnl <= '0;
      a2d_strt  <= 1'b0;
      sel       <= '0;
      last      <= LAST_RST;
      wdog      <= '0;
    end else begin
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      rd_res    <= rd_res_nxt;
      tmo_err   <= tmo_err_nxt;
      busy      <= busy_nxt;
      a2d_chnnl <= a2d_chnnl_nxt;
      a2d_strt  <= a2d_strt_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      wdog      <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: one default instance for arbitration,
// one with a 4-bit watchdog for timeout behaviour.
module tb_a2d_arbiter;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clr_err, a2d_cmplt, tmo_err, busy, a2d_strt;
  logic [N-1:0]   req, gnt, done;
  logic [3*N-1:0] req_chnnl;
  logic [11:0]    rd_res, a2d_res;
  logic [2:0]     a2d_chnnl;

  logic           w_clr_err, w_a2d_cmplt, w_tmo_err, w_busy, w_a2d_strt;
  logic [N-1:0]   w_req, w_gnt, w_done;
  logic [11:0]    w_rd_res, w_a2d_res;
  logic [2:0]     w_a2d_chnnl;

  a2d_arbiter #(.NUM_REQ(N)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl), .gnt(gnt), .done(done),
    .rd_res(rd_res), .tmo_err(tmo_err), .clr_err(clr_err), .busy(busy),
    .a2d_chnnl(a2d_chnnl), .a2d_strt(a2d_strt), .a2d_cmplt(a2d_cmplt), .a2d_res(a2d_res)
  );

  a2d_arbiter #(.NUM_REQ(N), .TMO_W(4)) u_wd (
    .clk(clk), .rst(rst), .req(w_req), .req_chnnl(req_chnnl), .gnt(w_gnt), .done(w_done),
    .rd_res(w_rd_res), .tmo_err(w_tmo_err), .clr_err(w_clr_err), .busy(w_busy),
    .a2d_chnnl(w_a2d_chnnl), .a2d_strt(w_a2d_strt), .a2d_cmplt(w_a2d_cmplt), .a2d_res(w_a2d_res)
  );

  typedef struct {
    logic         set_req;
    logic [N-1:0] req_v;
    int           exp_idx;
    logic [2:0]   exp_ch;
    int           dly;
    logic [11:0]  res;
    logic         drop_mid;
    logic [N-1:0] keep;
    logic         b2b;
  } vec_t;

  typedef struct {
    logic [N-1:0] onehot;
    logic [11:0]  res;
  } exp_t;

  exp_t sb[$];
  vec_t vecs [8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance, with the bench acting as A2D_intf.
  task automatic run_vec(input vec_t v);
    int   t;
    exp_t e;
    if (v.set_req) req = v.req_v;
    t = 0;
    while (!a2d_strt && t < 60) begin
      tick();
      t++;
    end
    chk("strt_seen", 32'(a2d_strt), 32'(1));
    if (v.b2b) chk("idle_gap", 32'(t), 32'(0));
    chk("gnt", 32'(gnt), 32'(1) << v.exp_idx);
    chk("chnl", 32'(a2d_chnnl), 32'(v.exp_ch));
    e.onehot = N'(1) << v.exp_idx;
    e.res    = v.res;
    sb.push_back(e);
    tick();
    chk("strt_pulse", 32'(a2d_strt), 32'(0));
    if (v.drop_mid) req[v.exp_idx] = 1'b0;
    repeat (v.dly - 1) tick();
    chk("early_done", 32'(done), 32'(0));
    a2d_cmplt = 1'b1;
    a2d_res   = v.res;
    tick();
    a2d_cmplt = 1'b0;
    a2d_res   = 12'h000;
    if (done == '0 || sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_missing: got done=0x%0h, expected a completion pulse", done);
    end else begin
      e = sb.pop_front();
      chk("done", 32'(done), 32'(e.onehot));
      chk("rd_res", 32'(rd_res), 32'(e.res));
    end
    chk("gnt_drop", 32'(gnt), 32'(0));
    chk("busy_drop", 32'(busy), 32'(0));
    req = req & v.keep;
    tick();
    chk("done_len", 32'(done), 32'(0));
  endtask

  task automatic w_wait_strt();
    int t;
    t = 0;
    while (!w_a2d_strt && t < 60) begin
      tick();
      t++;
    end
    chk("w_strt_seen", 32'(w_a2d_strt), 32'(1));
  endtask

  initial begin
    vec_t v;
    int   t;
    // {set_req, req, exp_idx, exp_ch, dly, res, drop_mid, keep, b2b}
    vecs[0] = '{1'b1, 3'b111, 0, 3'd5,  5, 12'h111, 1'b0, 3'b111, 1'b0};
    vecs[1] = '{1'b0, 3'b111, 1, 3'd6,  3, 12'h222, 1'b0, 3'b111, 1'b1};
    vecs[2] = '{1'b0, 3'b111, 2, 3'd2,  7, 12'h333, 1'b0, 3'b111, 1'b1};
    vecs[3] = '{1'b0, 3'b111, 0, 3'd5,  1, 12'h444, 1'b0, 3'b111, 1'b1};
    vecs[4] = '{1'b0, 3'b111, 1, 3'd6,  4, 12'h555, 1'b1, 3'b111, 1'b1};
    vecs[5] = '{1'b0, 3'b111, 2, 3'd2,  6, 12'h666, 1'b0, 3'b111, 1'b1};
    vecs[6] = '{1'b0, 3'b111, 0, 3'd5,  3, 12'h777, 1'b0, 3'b000, 1'b1};
    vecs[7] = '{1'b1, 3'b001, 0, 3'd5, 40, 12'hABC, 1'b0, 3'b000, 1'b0};

    rst = 1'b1; clr_err = 1'b0; a2d_cmplt = 1'b0; a2d_res = 12'h000; req = '0;
    req_chnnl = {3'd2, 3'd6, 3'd5};
    w_clr_err = 1'b0; w_a2d_cmplt = 1'b0; w_a2d_res = 12'h000; w_req = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_res", 32'(rd_res), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_tmo", 32'(tmo_err), 32'(0));
    chk("rst_strt", 32'(a2d_strt), 32'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    tick();
    chk("busy_after", 32'(busy), 32'(0));

    // Stray completion while idle must be ignored.
    a2d_cmplt = 1'b1;
    a2d_res   = 12'h123;
    tick();
    a2d_cmplt = 1'b0;
    chk("stray_done", 32'(done), 32'(0));
    tick();
    chk("stray_done2", 32'(done), 32'(0));
    chk("stray_rd_res", 32'(rd_res), 32'(12'hABC));
    chk("stray_busy", 32'(busy), 32'(0));

    // Reset in the middle of WAIT, then requester 0 must win first.
    req = 3'b100;
    t = 0;
    while (!a2d_strt && t < 60) begin
      tick();
      t++;
    end
    chk("mid_gnt", 32'(gnt), 32'(3'b100));
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mr_gnt", 32'(gnt), 32'(0));
    chk("mr_done", 32'(done), 32'(0));
    chk("mr_rd_res", 32'(rd_res), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_chnl", 32'(a2d_chnnl), 32'(0));
    chk("mr_strt", 32'(a2d_strt), 32'(0));
    chk("mr_tmo", 32'(tmo_err), 32'(0));
    req = 3'b111;
    tick();
    rst = 1'b0;
    v = '{1'b0, 3'b111, 0, 3'd5, 3, 12'h9C3, 1'b0, 3'b000, 1'b0};
    run_vec(v);

    // Watchdog instance: normal transfer so rd_res is non-zero first.
    w_req = 3'b001;
    w_wait_strt();
    repeat (3) tick();
    w_a2d_cmplt = 1'b1;
    w_a2d_res   = 12'hFED;
    tick();
    w_a2d_cmplt = 1'b0;
    w_req = '0;
    chk("w_ok_done", 32'(w_done), 32'(3'b001));
    chk("w_ok_res", 32'(w_rd_res), 32'(12'hFED));
    chk("w_ok_tmo", 32'(w_tmo_err), 32'(0));
    tick();

    // Timeout: done lands 16 cycles after the strt cycle (15 WAIT cycles).
    w_req = 3'b001;
    w_wait_strt();
    t = 0;
    while (!w_done && t < 40) begin
      tick();
      t++;
    end
    w_req = '0;
    chk("w_tmo_cycles", 32'(t), 32'(16));
    chk("w_tmo_done", 32'(w_done), 32'(3'b001));
    chk("w_tmo_res", 32'(w_rd_res), 32'(0));
    chk("w_tmo_err", 32'(w_tmo_err), 32'(1));
    repeat (3) tick();
    chk("w_sticky", 32'(w_tmo_err), 32'(1));
    w_clr_err = 1'b1;
    tick();
    w_clr_err = 1'b0;
    chk("w_clr", 32'(w_tmo_err), 32'(0));

    // Completion on the terminal-count cycle wins over the watchdog.
    w_req = 3'b001;
    w_wait_strt();
    repeat (14) tick();
    chk("w_tie_early", 32'(w_done), 32'(0));
    tick();
    w_a2d_cmplt = 1'b1;
    w_a2d_res   = 12'h5A5;
    tick();
    w_a2d_cmplt = 1'b0;
    w_req = '0;
    chk("w_tie_done", 32'(w_done), 32'(3'b001));
    chk("w_tie_res", 32'(w_rd_res), 32'(12'h5A5));
    chk("w_tie_tmo", 32'(w_tmo_err), 32'(0));
    tick();

    // clr_err coinciding with a new timeout: the set wins.
    w_req = 3'b001;
    w_wait_strt();
    repeat (14) tick();
    w_clr_err = 1'b1;
    tick();
    tick();
    w_clr_err = 1'b0;
    w_req = '0;
    chk("w_set_done", 32'(w_done), 32'(3'b001));
    chk("w_set_wins", 32'(w_tmo_err), 32'(1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
